// File: rtl/intrusion_detector.sv
// Debounced, latched intrusion alarm for ultrasonic range samples.
// Adds confirm/hold qualification, arm control and a sensor-loss watchdog.
module intrusion_detector #(
  parameter int THRESHOLD    = 100,
  parameter int HYST         = 10,
  parameter int CONFIRM      = 3,
  parameter int HOLD_SAMPLES = 8,
  parameter int TIMEOUT      = 2_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Arm,
  input  logic       Sample_Valid,
  input  logic [7:0] Distance,
  output logic       Alarm,
  output logic       Fault,
  output logic [2:0] State,
  output logic [7:0] Alarm_Count
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMED    = 3'd1,
    PENDING  = 3'd2,
    ALARM    = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam int CLR_SUM = THRESHOLD + HYST;
  localparam logic [8:0] THR = 9'(THRESHOLD);
  localparam logic [8:0] CLR =
    (CLR_SUM > 255) ? 9'd255 : 9'(CLR_SUM);
  localparam logic [3:0] NEAR_LAST = 4'(CONFIRM - 1);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_SAMPLES - 1);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t         state;
  logic           arm_q1;
  logic           arm_s;
  logic [3:0]     near_cnt;
  logic [7:0]     hold_cnt;
  logic [WDW-1:0] wd_cnt;
  logic           accepted;
  logic           near;
  logic           clear;
  logic           fault_set;
  logic           raise;

  assign State     = state;
  assign accepted  = Sample_Valid && (Distance != 8'd0);
  assign near      = {1'b0, Distance} < THR;
  assign clear     = {1'b0, Distance} >= CLR;
  assign fault_set = !accepted && (wd_cnt == WD_LAST);

  // Entry into ALARM that is counted: confirmation or tamper.
  always_comb begin
    raise = 1'b0;
    if (arm_s) begin
      unique case (state)
        ARMED:
          raise = fault_set ||
                  (accepted && near && CONFIRM == 1);
        PENDING:
          raise = fault_set ||
                  (accepted && near && near_cnt == NEAR_LAST);
        default: raise = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wd_cnt <= '0;
      Fault  <= 1'b0;
    end else if (accepted) begin
      wd_cnt <= '0;
      Fault  <= 1'b0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_LAST) Fault <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      arm_q1      <= 1'b0;
      arm_s       <= 1'b0;
      state       <= DISARMED;
      near_cnt    <= '0;
      hold_cnt    <= '0;
      Alarm       <= 1'b0;
      Alarm_Count <= '0;
    end else begin
      arm_q1 <= Arm;
      arm_s  <= arm_q1;
      if (!arm_s) begin
        state    <= DISARMED;
        near_cnt <= '0;
        hold_cnt <= '0;
        Alarm    <= 1'b0;
      end else if (raise) begin
        state    <= ALARM;
        near_cnt <= '0;
        Alarm    <= 1'b1;
        if (Alarm_Count != 8'hFF)
          Alarm_Count <= Alarm_Count + 8'd1;
      end else begin
        unique case (state)
          DISARMED: state <= ARMED;
          ARMED: begin
            if (accepted && near) begin
              state    <= PENDING;
              near_cnt <= 4'd1;
            end
          end
          PENDING: begin
            if (accepted) begin
              if (near) begin
                near_cnt <= near_cnt + 4'd1;
              end else begin
                state    <= ARMED;
                near_cnt <= '0;
              end
            end
          end
          ALARM: begin
            if (accepted && clear) begin
              if (HOLD_SAMPLES == 1) begin
                state <= ARMED;
                Alarm <= 1'b0;
              end else begin
                state    <= HOLD;
                hold_cnt <= HOLD_INIT;
              end
            end
          end
          HOLD: begin
            // hold_cnt is the number of clear samples still required
            if (accepted) begin
              if (!clear) begin
                state    <= ALARM;
                hold_cnt <= '0;
              end else if (hold_cnt <= 8'd1) begin
                hold_cnt <= '0;
                if (!Fault) begin
                  state <= ARMED;
                  Alarm <= 1'b0;
                end
              end else begin
                hold_cnt <= hold_cnt - 8'd1;
              end
            end
          end
          default: begin
            state <= DISARMED;
            Alarm <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_intrusion_detector.sv
// Directed bench for intrusion_detector.
// Short watchdog timeout keeps the run small.
module tb_intrusion_detector;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Arm;
  logic       Sample_Valid;
  logic [7:0] Distance;
  logic       Alarm;
  logic       Fault;
  logic [2:0] State;
  logic [7:0] Alarm_Count;

  int total = 0;
  int bad   = 0;

  localparam int TO = 400;
  localparam logic [2:0] S_DIS  = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_PEND = 3'd2;
  localparam logic [2:0] S_ALM  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  intrusion_detector #(
    .THRESHOLD(100),
    .HYST(10),
    .CONFIRM(3),
    .HOLD_SAMPLES(8),
    .TIMEOUT(TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Arm(Arm),
    .Sample_Valid(Sample_Valid),
    .Distance(Distance),
    .Alarm(Alarm),
    .Fault(Fault),
    .State(State),
    .Alarm_Count(Alarm_Count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sample(input logic [7:0] d);
    Sample_Valid = 1'b1;
    Distance     = d;
    tick();
    Sample_Valid = 1'b0;
    Distance     = 8'd0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b0;
    Arm = 1'b0;
    Sample_Valid = 1'b0;
    Distance = 8'd0;
    idle(2);
    chk("rst_state", 32'(State), 32'(S_DIS));
    chk("rst_alarm", 32'(Alarm), 0);
    chk("rst_fault", 32'(Fault), 0);
    chk("rst_count", 32'(Alarm_Count), 0);

    RST = 1'b1;
    Arm = 1'b1;
    idle(2);
    chk("arm_lat_k1", 32'(State), 32'(S_DIS));
    tick();
    chk("arm_lat_k2", 32'(State), 32'(S_ARM));

    sample(8'd50);
    chk("cf_1", 32'(State), 32'(S_PEND));
    idle(99);
    sample(8'd50);
    chk("cf_2", 32'(State), 32'(S_PEND));
    chk("cf_2_alarm", 32'(Alarm), 0);
    idle(99);
    sample(8'd50);
    chk("cf_3", 32'(State), 32'(S_ALM));
    chk("cf_3_alarm", 32'(Alarm), 1);
    chk("cf_3_count", 32'(Alarm_Count), 1);

    sample(8'd105);
    chk("hy_band", 32'(State), 32'(S_ALM));
    sample(8'd110);
    chk("hy_hold", 32'(State), 32'(S_HOLD));
    chk("hy_hold_alarm", 32'(Alarm), 1);
    repeat (4) sample(8'd110);
    chk("hy_5th", 32'(State), 32'(S_HOLD));
    sample(8'd60);
    chk("hy_back", 32'(State), 32'(S_ALM));
    chk("hy_back_count", 32'(Alarm_Count), 1);
    repeat (7) sample(8'd110);
    chk("hy_7th", 32'(State), 32'(S_HOLD));
    chk("hy_7th_alarm", 32'(Alarm), 1);
    sample(8'd110);
    chk("hy_8th", 32'(State), 32'(S_ARM));
    chk("hy_8th_alarm", 32'(Alarm), 0);

    sample(8'd50);
    sample(8'd50);
    chk("db_pend", 32'(State), 32'(S_PEND));
    sample(8'd120);
    chk("db_reset", 32'(State), 32'(S_ARM));
    sample(8'd50);
    sample(8'd50);
    chk("db_end", 32'(State), 32'(S_PEND));
    chk("db_alarm", 32'(Alarm), 0);
    sample(8'd120);
    chk("db_clear", 32'(State), 32'(S_ARM));

    Sample_Valid = 1'b1;
    Distance = 8'd0;
    idle(TO - 1);
    chk("wd_pre_fault", 32'(Fault), 0);
    chk("wd_pre_state", 32'(State), 32'(S_ARM));
    tick();
    chk("wd_fault", 32'(Fault), 1);
    chk("wd_tamper", 32'(State), 32'(S_ALM));
    chk("wd_count", 32'(Alarm_Count), 2);
    Sample_Valid = 1'b0;
    sample(8'd150);
    chk("wd_clr_fault", 32'(Fault), 0);
    chk("wd_hold", 32'(State), 32'(S_HOLD));

    repeat (6) sample(8'd110);
    idle(TO);
    chk("hf_fault", 32'(Fault), 1);
    chk("hf_state", 32'(State), 32'(S_HOLD));
    sample(8'd110);
    chk("hf_stuck", 32'(State), 32'(S_HOLD));
    chk("hf_fault_clr", 32'(Fault), 0);
    sample(8'd110);
    chk("hf_exit", 32'(State), 32'(S_ARM));

    repeat (3) sample(8'd50);
    chk("dp_alarm", 32'(State), 32'(S_ALM));
    chk("dp_count", 32'(Alarm_Count), 3);
    Arm = 1'b0;
    sample(8'd50);
    chk("dp_k", 32'(State), 32'(S_ALM));
    tick();
    chk("dp_k1", 32'(State), 32'(S_ALM));
    tick();
    chk("dp_k2", 32'(State), 32'(S_DIS));
    chk("dp_k2_alarm", 32'(Alarm), 0);
    chk("dp_k2_count", 32'(Alarm_Count), 3);

    Arm = 1'b1;
    idle(3);
    chk("rearm", 32'(State), 32'(S_ARM));
    sample(8'd50);
    sample(8'd50);
    chk("pr_pend", 32'(State), 32'(S_PEND));
    Arm = 1'b0;
    idle(2);
    sample(8'd50);
    chk("pr_state", 32'(State), 32'(S_DIS));
    chk("pr_count", 32'(Alarm_Count), 3);

    Arm = 1'b1;
    idle(3);
    for (int i = 0; i < 300; i++) begin
      repeat (3) sample(8'd50);
      repeat (8) sample(8'd110);
    end
    chk("sat_count", 32'(Alarm_Count), 255);
    chk("sat_state", 32'(State), 32'(S_ARM));
    repeat (3) sample(8'd50);
    chk("sat_hold", 32'(Alarm_Count), 255);
    repeat (3) sample(8'd110);
    chk("sat_in_hold", 32'(State), 32'(S_HOLD));
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("mr_state", 32'(State), 32'(S_DIS));
    chk("mr_alarm", 32'(Alarm), 0);
    chk("mr_fault", 32'(Fault), 0);
    chk("mr_count", 32'(Alarm_Count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
